// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - frame-rate game-state controller: levels, lives, saturating score, hi-score.
// Optional bonus lives on score milestones when GAME_FSM_BONUS_LIFE_EN is defined.
module game_fsm #(
  parameter int         SCORE_W      = 9,
  parameter int         NUM_LEVELS   = 4,
  parameter int         LIVES        = 3,
  parameter int         HIT_POINTS   = 1,
  parameter int         DELAY_FRAMES = 60,
  parameter logic [7:0] START_KEY    = 8'h28,
  parameter logic [7:0] PAUSE_KEY    = 8'h13
`ifdef GAME_FSM_BONUS_LIFE_EN
  ,
  parameter int         BONUS_SCORE  = 50,
  parameter int         MAX_LIVES    = 5
`endif
) (
  input  logic                            frame_clk,
  input  logic                            Reset,
  input  logic [15:0]                     keycode,
  input  logic                            hit,
  input  logic                            collision,
  input  logic                            wave_cleared,
  output logic [2:0]                      state,
  output logic [$clog2(NUM_LEVELS)-1:0]   level,
`ifdef GAME_FSM_BONUS_LIFE_EN
  output logic [$clog2(MAX_LIVES+1)-1:0]  lives,
`else
  output logic [$clog2(LIVES+1)-1:0]      lives,
`endif
  output logic [SCORE_W-1:0]              score,
  output logic [SCORE_W-1:0]              hi_score,
  output logic                            playing,
  output logic                            lost_game,
  output logic                            wave_start
);

`ifdef GAME_FSM_BONUS_LIFE_EN
  localparam int LW = $clog2(MAX_LIVES + 1);
`else
  localparam int LW = $clog2(LIVES + 1);
`endif
  localparam int LVW = $clog2(NUM_LEVELS);
  localparam int CW  = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_PLAY      = 3'd1,
    S_PAUSED    = 3'd2,
    S_RESPAWN   = 3'd3,
    S_CLEAR     = 3'd4,
    S_GAME_OVER = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LVW-1:0]     level_q, level_d;
  logic [LW-1:0]      lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d, hi_q, hi_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               start_dn_q, start_dn_d, pause_dn_q, pause_dn_d;
  logic               playing_q, playing_d, lost_q, lost_d, wave_q, wave_d;
  logic               start_press, pause_press;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
`ifdef GAME_FSM_BONUS_LIFE_EN
  logic               bonus;
  logic [LW:0]        lives_sum;
`endif

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    score_d    = score_q;
    cnt_d      = cnt_q;
    start_dn_d = (keycode[7:0] == START_KEY) || (keycode[15:8] == START_KEY);
    pause_dn_d = (keycode[7:0] == PAUSE_KEY) || (keycode[15:8] == PAUSE_KEY);
    start_press = start_dn_d && !start_dn_q;
    pause_press = pause_dn_d && !pause_dn_q;
    // The carry out of the widened sum marks overflow; clamp instead of wrapping.
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(HIT_POINTS);
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`ifdef GAME_FSM_BONUS_LIFE_EN
    bonus     = 1'b0;
    lives_sum = '0;
`endif

    case (state_q)
      S_START: begin
        score_d = '0;
        level_d = '0;
        lives_d = LW'(LIVES);
        if (start_press) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit) score_d = score_sat;
`ifdef GAME_FSM_BONUS_LIFE_EN
        bonus     = hit && ((int'(score_d) / BONUS_SCORE) > (int'(score_q) / BONUS_SCORE));
        lives_sum = {1'b0, lives_q} + (LW+1)'(bonus) - (LW+1)'(collision);
        if (lives_sum > (LW+1)'(MAX_LIVES)) lives_sum = (LW+1)'(MAX_LIVES);
        lives_d   = lives_sum[LW-1:0];
        if (collision) begin
          state_d = (lives_sum == '0) ? S_GAME_OVER : S_RESPAWN;
          cnt_d   = CW'(DELAY_FRAMES - 1);
        end
`else
        if (collision) begin
          lives_d = lives_q - LW'(1);
          state_d = (lives_q == LW'(1)) ? S_GAME_OVER : S_RESPAWN;
          cnt_d   = CW'(DELAY_FRAMES - 1);
        end
`endif
        else if (wave_cleared) begin
          state_d = S_CLEAR;
          cnt_d   = CW'(DELAY_FRAMES - 1);
        end else if (pause_press) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_press) state_d = S_PLAY;
      end
      S_RESPAWN: begin
        if (cnt_q == '0) state_d = S_PLAY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          level_d = (level_q == LVW'(NUM_LEVELS - 1)) ? '0 : level_q + LVW'(1);
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAME_OVER: begin
        if (start_press) begin
          state_d = S_PLAY;
          score_d = '0;
          level_d = '0;
          lives_d = LW'(LIVES);
        end
      end
      default: state_d = S_START;
    endcase

    hi_d      = (score_d > hi_q) ? score_d : hi_q;
    playing_d = (state_d == S_PLAY);
    lost_d    = (state_d == S_GAME_OVER);
    // Only entries that begin a fresh wave reload enemies; returns from pause/respawn do not.
    wave_d    = (state_d == S_PLAY) &&
                ((state_q == S_START) || (state_q == S_CLEAR) || (state_q == S_GAME_OVER));
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_START;
      level_q    <= '0;
      lives_q    <= LW'(LIVES);
      score_q    <= '0;
      hi_q       <= '0;
      cnt_q      <= '0;
      start_dn_q <= 1'b0;
      pause_dn_q <= 1'b0;
      playing_q  <= 1'b0;
      lost_q     <= 1'b0;
      wave_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      start_dn_q <= start_dn_d;
      pause_dn_q <= pause_dn_d;
      playing_q  <= playing_d;
      lost_q     <= lost_d;
      wave_q     <= wave_d;
    end
  end

  assign state      = state_q;
  assign level      = level_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign hi_score   = hi_q;
  assign playing    = playing_q;
  assign lost_game  = lost_q;
  assign wave_start = wave_q;

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - scoreboard bench for game_fsm; a frame model queues expected outputs per frame.
module tb_game_fsm;
  localparam int SW = 4, NL = 4, NLIVES = 3, DLY = 60;
`ifdef GAME_FSM_BONUS_LIFE_EN
  localparam int BONUS = 2, MAXL = 5, LWB = 3;
`else
  localparam int MAXL = NLIVES, LWB = 2;
`endif

  logic           frame_clk = 1'b0;
  logic           Reset;
  logic [15:0]    keycode;
  logic           hit, collision, wave_cleared;
  logic [2:0]     state;
  logic [1:0]     level;
  logic [LWB-1:0] lives;
  logic [SW-1:0]  score, hi_score;
  logic           playing, lost_game, wave_start;

  always #5 frame_clk = ~frame_clk;

  game_fsm #(
    .SCORE_W(SW)
`ifdef GAME_FSM_BONUS_LIFE_EN
    , .BONUS_SCORE(BONUS)
`endif
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .hit(hit),
    .collision(collision), .wave_cleared(wave_cleared), .state(state),
    .level(level), .lives(lives), .score(score), .hi_score(hi_score),
    .playing(playing), .lost_game(lost_game), .wave_start(wave_start)
  );

  typedef struct {
    int st, lvl, lv, sc, hi, pl, lg, ws;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, bad = 0;
  int   m_st, m_lvl, m_lives, m_score, m_hi, m_cnt;
  bit   m_sd, m_pd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function void model_reset();
    m_st = 0; m_lvl = 0; m_lives = NLIVES; m_score = 0; m_hi = 0; m_cnt = 0;
    m_sd = 0; m_pd = 0;
  endfunction

  function exp_t model_step(input logic [15:0] kc, input logic h, input logic c, input logic w);
    exp_t e;
    int   prev, smax, bon;
    bit   sd, sp, pd, pp;
`ifdef GAME_FSM_BONUS_LIFE_EN
    int   old;
    old = m_score;
`endif
    smax = (1 << SW) - 1;
    sd = (kc[7:0] == 8'h28) || (kc[15:8] == 8'h28);
    pd = (kc[7:0] == 8'h13) || (kc[15:8] == 8'h13);
    sp = sd && !m_sd;
    pp = pd && !m_pd;
    m_sd = sd;
    m_pd = pd;
    prev = m_st;
    bon = 0;
    case (m_st)
      0: begin
        m_score = 0; m_lvl = 0; m_lives = NLIVES;
        if (sp) m_st = 1;
      end
      1: begin
        if (h) m_score = (m_score + 1 > smax) ? smax : m_score + 1;
`ifdef GAME_FSM_BONUS_LIFE_EN
        if (h && (m_score / BONUS > old / BONUS)) bon = 1;
`endif
        m_lives = m_lives + bon - (c ? 1 : 0);
        if (m_lives > MAXL) m_lives = MAXL;
        if (c) begin
          if (m_lives == 0) m_st = 5;
          else begin m_st = 3; m_cnt = DLY - 1; end
        end else if (w) begin
          m_st = 4; m_cnt = DLY - 1;
        end else if (pp) begin
          m_st = 2;
        end
      end
      2: if (pp) m_st = 1;
      3: if (m_cnt == 0) m_st = 1; else m_cnt--;
      4: if (m_cnt == 0) begin m_lvl = (m_lvl + 1) % NL; m_st = 1; end else m_cnt--;
      5: if (sp) begin m_st = 1; m_score = 0; m_lvl = 0; m_lives = NLIVES; end
      default: m_st = 0;
    endcase
    if (m_score > m_hi) m_hi = m_score;
    e.st = m_st; e.lvl = m_lvl; e.lv = m_lives; e.sc = m_score; e.hi = m_hi;
    e.pl = (m_st == 1) ? 1 : 0;
    e.lg = (m_st == 5) ? 1 : 0;
    e.ws = ((m_st == 1) && (prev == 0 || prev == 4 || prev == 5)) ? 1 : 0;
    return e;
  endfunction

  task automatic drive(input logic [15:0] kc, input logic h, input logic c, input logic w);
    @(negedge frame_clk);
    keycode = kc; hit = h; collision = c; wave_cleared = w;
    sb.push_back(model_step(kc, h, c, w));
    @(posedge frame_clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge frame_clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("state", 32'(state), mon_e.st);
      check("level", 32'(level), mon_e.lvl);
      check("lives", 32'(lives), mon_e.lv);
      check("score", 32'(score), mon_e.sc);
      check("hi_score", 32'(hi_score), mon_e.hi);
      check("playing", 32'(playing), mon_e.pl);
      check("lost_game", 32'(lost_game), mon_e.lg);
      check("wave_start", 32'(wave_start), mon_e.ws);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int guard;
    Reset = 1'b0; keycode = '0; hit = 1'b0; collision = 1'b0; wave_cleared = 1'b0;
    model_reset();
    repeat (3) @(posedge frame_clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_level", 32'(level), 0);
    check("rst_lives", 32'(lives), NLIVES);
    check("rst_score", 32'(score), 0);
    check("rst_hi", 32'(hi_score), 0);
    check("rst_flags", {29'd0, playing, lost_game, wave_start}, 0);
    @(negedge frame_clk);
    Reset = 1'b1;
    idle(2);

    drive(16'h2800, 1'b0, 1'b0, 1'b0);
    check("start_ws", 32'(wave_start), 1);
    check("start_state", 32'(state), 1);
    drive(16'h2800, 1'b0, 1'b0, 1'b0);
    check("start_ws_one", 32'(wave_start), 0);
    idle(1);

    repeat (5) drive(16'h0000, 1'b1, 1'b0, 1'b0);
    check("hits_score", 32'(score), 5);
    check("hits_hi", 32'(hi_score), 5);
    for (int i = 0; i < 10; i++) drive(16'h0013, 1'(i % 2), 1'b0, 1'b0);
    check("pause_state", 32'(state), 2);
    check("pause_score", 32'(score), 5);
    drive(16'h0000, 1'b1, 1'b1, 1'b1);
    check("pause_ignore", 32'(state), 2);
    drive(16'h1300, 1'b0, 1'b0, 1'b0);
    check("unpause_state", 32'(state), 1);
    check("unpause_ws", 32'(wave_start), 0);

    drive(16'h0000, 1'b0, 1'b1, 1'b1);
    check("respawn_state", 32'(state), 3);
`ifndef GAME_FSM_BONUS_LIFE_EN
    check("respawn_lives", 32'(lives), 2);
`endif
    for (int i = 0; i < DLY - 1; i++)
      drive((i % 4 == 0) ? 16'h0013 : 16'h0000, 1'(i % 3 == 0), 1'(i % 5 == 0), 1'(i % 7 == 0));
    check("respawn_hold", 32'(state), 3);
    idle(1);
    check("respawn_done", 32'(state), 1);
    check("respawn_ws", 32'(wave_start), 0);

    for (int lv = 1; lv <= 4; lv++) begin
      drive(16'h0000, 1'b0, 1'b0, 1'b1);
      check("clear_state", 32'(state), 4);
      idle(DLY - 1);
      check("clear_hold", 32'(state), 4);
      idle(1);
      check("clear_level", 32'(level), lv % NL);
      check("clear_ws", 32'(wave_start), 1);
    end

    repeat (20) drive(16'h0000, 1'b1, 1'b0, 1'b0);
    check("sat_score", 32'(score), 15);
    check("sat_hi", 32'(hi_score), 15);

    guard = 0;
    while (state != 3'd5 && guard < 8) begin
      drive(16'h0000, 1'b0, 1'b1, 1'b0);
      if (state == 3'd3) idle(DLY);
      guard++;
    end
    check("gameover_state", 32'(state), 5);
    check("gameover_lost", 32'(lost_game), 1);
    drive(16'h0000, 1'b1, 1'b0, 1'b0);
    check("gameover_hold", 32'(score), 15);
    drive(16'h0028, 1'b0, 1'b0, 1'b0);
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_hi", 32'(hi_score), 15);
    check("restart_lives", 32'(lives), NLIVES);
    check("restart_ws", 32'(wave_start), 1);

`ifdef GAME_FSM_BONUS_LIFE_EN
    repeat (4) drive(16'h0000, 1'b1, 1'b0, 1'b0);
    check("bonus_lives", 32'(lives), 5);
    repeat (2) drive(16'h0000, 1'b1, 1'b0, 1'b0);
    check("bonus_cap", 32'(lives), 5);
    drive(16'h0000, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b1, 1'b1, 1'b0);
    check("bonus_coll_lives", 32'(lives), 5);
    check("bonus_coll_state", 32'(state), 3);
    idle(DLY);
`endif

    drive(16'h0013, 1'b0, 1'b0, 1'b0);
    check("pre_rst_pause", 32'(state), 2);
    @(negedge frame_clk);
    #2;
    Reset = 1'b0;
    keycode = '0;
    model_reset();
    #1;
    check("rst_pause_state", 32'(state), 0);
    check("rst_pause_hi", 32'(hi_score), 0);
    @(negedge frame_clk);
    Reset = 1'b1;

    drive(16'h2800, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("pre_rst_delay", 32'(state), 3);
    @(negedge frame_clk);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check("rst_delay_state", 32'(state), 0);
    check("rst_delay_lives", 32'(lives), NLIVES);
    @(negedge frame_clk);
    Reset = 1'b1;
    idle(2);
    drive(16'h2800, 1'b0, 1'b0, 1'b0);
    check("final_play", 32'(state), 1);
    idle(1);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
